// File: rtl/fp_vector_alu_stream.sv
// Streaming FP vector ALU: elementwise multiply, masked dot product and scalar scale.
// Results return in issue order through a credit-protected first-word-fall-through FIFO.
`timescale 1ns/1ps
module fp_vector_alu_stream #(
  parameter int WIDTH        = 32,
  parameter int NUM_INPUTS   = 4,
  parameter int MULT_LATENCY = 8,
  parameter int DOT_LATENCY  = 42,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    in_op,
  input  logic [WIDTH*NUM_INPUTS-1:0]   in_a,
  input  logic [WIDTH*NUM_INPUTS-1:0]   in_b,
  input  logic [WIDTH-1:0]              in_c,
  input  logic [NUM_INPUTS-1:0]         in_enable,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH*NUM_INPUTS-1:0]   out_data,
  output logic [1:0]                    out_op,
  output logic                          out_err
);

  localparam int EXP_W = (WIDTH == 64) ? 11 : (WIDTH == 16) ? 5 : 8;
  localparam int MAN_W = WIDTH - EXP_W - 1;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX  = (1 << EXP_W) - 1;
  localparam int XW    = MAN_W + 5;  // carry + hidden + mantissa + guard/round/sticky
  localparam int VW    = WIDTH * NUM_INPUTS;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {OP_MULT = 2'd0, OP_DOT = 2'd1, OP_SCALE = 2'd2, OP_ILL = 2'd3} op_e;

  // Round-to-nearest-even, then saturate to infinity or flush underflow to signed zero.
  function automatic logic [WIDTH-1:0] round_pack(input logic s, input int e_in,
                                                  input logic [MAN_W-1:0] m,
                                                  input logic g, input logic st);
    logic [MAN_W:0] r;
    int             e;
    e = e_in;
    r = {1'b0, m};
    if (g && (st || m[0])) r = r + (MAN_W+1)'(1);
    if (r[MAN_W]) e = e + 1;
    if (e >= EMAX)   round_pack = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e <= 0) round_pack = {s, {(WIDTH-1){1'b0}}};
    else             round_pack = {s, e[EXP_W-1:0], r[MAN_W-1:0]};
  endfunction

  // Subnormal inputs are treated as zero.
  function automatic logic [WIDTH-1:0] fp_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic                 s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0]     ea, eb;
    logic [2*MAN_W+1:0]   p;
    int                   e;
    s      = a[WIDTH-1] ^ b[WIDTH-1];
    ea     = a[WIDTH-2 -: EXP_W];
    eb     = b[WIDTH-2 -: EXP_W];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (a[MAN_W-1:0] == '0);
    b_inf  = (eb == '1) && (b[MAN_W-1:0] == '0);
    a_nan  = (ea == '1) && (a[MAN_W-1:0] != '0);
    b_nan  = (eb == '1) && (b[MAN_W-1:0] != '0);
    p = {{(MAN_W+1){1'b0}}, 1'b1, a[MAN_W-1:0]} * {{(MAN_W+1){1'b0}}, 1'b1, b[MAN_W-1:0]};
    e = int'(ea) + int'(eb) - BIAS;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) fp_mul = QNAN;
    else if (a_inf || b_inf)   fp_mul = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (a_zero || b_zero) fp_mul = {s, {(WIDTH-1){1'b0}}};
    else if (p[2*MAN_W+1])     fp_mul = round_pack(s, e + 1, p[2*MAN_W -: MAN_W], p[MAN_W], |p[MAN_W-1:0]);
    else                       fp_mul = round_pack(s, e, p[2*MAN_W-1 -: MAN_W], p[MAN_W-1], |p[MAN_W-2:0]);
  endfunction

  function automatic logic [WIDTH-1:0] fp_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x, y;
    logic [EXP_W-1:0] ex, ey;
    logic [XW-1:0]    mx, my, sum;
    logic             st;
    int               d, e;
    // Order by magnitude so alignment only ever shifts the smaller operand.
    if (b[WIDTH-2:0] > a[WIDTH-2:0]) begin x = b; y = a; end
    else                             begin x = a; y = b; end
    ex = x[WIDTH-2 -: EXP_W];
    ey = y[WIDTH-2 -: EXP_W];
    mx = {2'b01, x[MAN_W-1:0], 3'b000};
    my = {2'b01, y[MAN_W-1:0], 3'b000};
    d  = int'(ex) - int'(ey);
    if (d >= XW) my = XW'(1);
    else begin
      st = 1'b0;
      for (int i = 0; i < XW; i++) if (i < d) st = st | my[i];
      my = (my >> d) | XW'(st);
    end
    e   = int'(ex);
    sum = (x[WIDTH-1] == y[WIDTH-1]) ? mx + my : mx - my;
    if (sum[XW-1]) begin
      sum = {1'b0, sum[XW-1:2], sum[1] | sum[0]};
      e   = e + 1;
    end else begin
      for (int i = 0; i < MAN_W + 3; i++) begin
        if (!sum[XW-2]) begin
          sum = sum << 1;
          e   = e - 1;
        end
      end
    end
    if (ex == '1)
      fp_add = ((x[MAN_W-1:0] != '0) || ((ey == '1) && (x[WIDTH-1] != y[WIDTH-1]))) ? QNAN : x;
    else if (ex == '0)  fp_add = {x[WIDTH-1] & y[WIDTH-1], {(WIDTH-1){1'b0}}};
    else if (ey == '0)  fp_add = x;
    else if (sum == '0) fp_add = '0;
    else                fp_add = round_pack(x[WIDTH-1], e, sum[XW-3 -: MAN_W], sum[2], sum[1] | sum[0]);
  endfunction

  op_e              w_op;
  logic             w_is_m, w_accept, w_push, w_pop, w_m_exit, w_d_exit;
  logic [VW-1:0]    w_prod, w_push_data;
  logic [WIDTH-1:0] w_dot;
  logic [1:0]       w_push_op;
  logic [CNT_W:0]   w_credits_used;

  logic [MULT_LATENCY-1:0] r_m_vld;
  logic [DOT_LATENCY-1:0]  r_d_vld;
  logic [VW-1:0]           r_m_data [MULT_LATENCY];
  logic [1:0]              r_m_op   [MULT_LATENCY];
  logic [WIDTH-1:0]        r_d_data [DOT_LATENCY];
  logic [VW-1:0]           r_fifo_data [FIFO_DEPTH];
  logic [1:0]              r_fifo_op   [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]        r_inflight, r_d_inflight, r_fifo_cnt;

  assign w_op     = op_e'(in_op);
  assign w_is_m   = (w_op != OP_DOT);
  assign w_accept = in_valid && in_ready;

  // SCALE reuses the multiplier bank with the scalar broadcast into the b operand.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_prod = '0;
    w_dot  = in_c;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_prod[WIDTH*i +: WIDTH] = fp_mul(in_a[WIDTH*i +: WIDTH],
                                        (w_op == OP_SCALE) ? in_c : in_b[WIDTH*i +: WIDTH]);
      if (in_enable[i]) w_dot = fp_add(w_dot, w_prod[WIDTH*i +: WIDTH]);
    end
  end

  // The ordering rules guarantee the two pipeline exits never coincide.
  assign w_m_exit    = r_m_vld[MULT_LATENCY-1];
  assign w_d_exit    = r_d_vld[DOT_LATENCY-1];
  assign w_push      = w_m_exit || w_d_exit;
  assign w_push_data = w_d_exit ? VW'(r_d_data[DOT_LATENCY-1]) : r_m_data[MULT_LATENCY-1];
  assign w_push_op   = w_d_exit ? OP_DOT : r_m_op[MULT_LATENCY-1];
  assign w_pop       = out_valid && out_ready;

  assign w_credits_used = {1'b0, r_inflight} + {1'b0, r_fifo_cnt};
  assign in_ready = !rst && (w_credits_used < (CNT_W+1)'(FIFO_DEPTH))
                    && !(w_is_m && (r_d_inflight != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_vld      <= '0;
      r_d_vld      <= '0;
      r_inflight   <= '0;
      r_d_inflight <= '0;
      r_fifo_cnt   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_m_vld      <= (r_m_vld << 1) | MULT_LATENCY'(w_accept && w_is_m);
      r_d_vld      <= (r_d_vld << 1) | DOT_LATENCY'(w_accept && !w_is_m);
      r_inflight   <= r_inflight + CNT_W'(w_accept) - CNT_W'(w_push);
      r_d_inflight <= r_d_inflight + CNT_W'(w_accept && !w_is_m) - CNT_W'(w_d_exit);
      r_fifo_cnt   <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: payload and FIFO storage are deliberately unreset; valid tags and counters alone decide what is live.
  always_ff @(posedge clk) begin
    r_m_data[0] <= w_prod;
    r_m_op[0]   <= in_op;
    r_d_data[0] <= w_dot;
    for (int k = 1; k < MULT_LATENCY; k++) begin
      r_m_data[k] <= r_m_data[k-1];
      r_m_op[k]   <= r_m_op[k-1];
    end
    for (int k = 1; k < DOT_LATENCY; k++) r_d_data[k] <= r_d_data[k-1];
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_push_data;
      r_fifo_op[r_wr_ptr]   <= w_push_op;
    end
  end

  assign out_valid = !rst && (r_fifo_cnt != '0);
  assign out_data  = out_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign out_op    = out_valid ? r_fifo_op[r_rd_ptr] : '0;
  assign out_err   = out_valid && (r_fifo_op[r_rd_ptr] == OP_ILL);

endmodule

// File: tb/tb_fp_vector_alu_stream.sv
// Scoreboard bench for fp_vector_alu_stream: directed vectors push expected results,
// an independent monitor pops and compares whenever a result is consumed.
`timescale 1ns/1ps
module tb_fp_vector_alu_stream;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int DW = W * N;

  localparam logic [31:0] ONE = 32'h3F800000, TWO = 32'h40000000, THREE = 32'h40400000;
  localparam logic [31:0] SIX = 32'h40C00000, THIRTEEN = 32'h41500000, JUNK = 32'h12345678;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0]    in_op, out_op;
  logic [DW-1:0] in_a, in_b, out_data;
  logic [W-1:0]  in_c;
  logic [N-1:0]  in_enable;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    op;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_vector_alu_stream #(
    .WIDTH(W), .NUM_INPUTS(N), .MULT_LATENCY(8), .DOT_LATENCY(42), .FIFO_DEPTH(64)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_enable(in_enable),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_op(out_op), .out_err(out_err)
  );

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge, where a consumed result is stable.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got data=%0h op=%0d with no result pending", out_data, out_op);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", out_data, mon_e.data);
        check("out_op", DW'(out_op), DW'(mon_e.op));
        check("out_err", DW'(out_err), DW'(mon_e.err));
        if (mon_e.cyc >= 0) check("out_cycle", DW'(cyc), DW'(mon_e.cyc));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [W-1:0] c, input logic [N-1:0] en,
                       input logic [DW-1:0] exp_data, input int lat, input bit push,
                       output int t_acc);
    exp_t e;
    int   waited;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_c = c; in_enable = en;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op %0d not accepted within 100 cycles", op);
      t_acc = -1;
    end else begin
      t_acc = cyc;
      if (push) begin
        e.data = exp_data;
        e.op   = op;
        e.err  = (op == 2'd3);
        e.cyc  = (lat >= 0) ? t_acc + lat + 1 : -1;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, t1, accepted, seen;
    rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0; in_c = '0;
    in_enable = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", DW'(in_ready), '0);
    check("rst_out_valid", DW'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_op_err", DW'({out_op, out_err}), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", DW'(in_ready), DW'(1));
    check("idle_out_valid", DW'(out_valid), '0);
    @(posedge clk); #1;

    // MULT: 2.0 * 3.0 in every lane, visible at t+9
    issue(2'd0, {4{TWO}}, {4{THREE}}, JUNK, 4'b0000, {4{SIX}}, 8, 1'b1, t0);
    drain();
    // MULT with mixed signs, zero and fractions
    issue(2'd0, {32'hBFC00000, 32'h3F000000, 32'h00000000, 32'h41200000},
                {32'h40000000, 32'h3E800000, 32'h40A00000, 32'hC0400000}, JUNK, 4'b1111,
                {32'hC0400000, 32'h3E000000, 32'h00000000, 32'hC1F00000}, 8, 1'b1, t0);
    drain();

    // DOT: lanes 0 and 2 enabled, 6+6+1 = 13, visible at t+43
    issue(2'd1, {4{TWO}}, {4{THREE}}, ONE, 4'b0101, {96'd0, THIRTEEN}, 42, 1'b1, t0);
    drain();
    // DOT with empty mask returns the addend
    issue(2'd1, {4{TWO}}, {4{THREE}}, ONE, 4'b0000, {96'd0, ONE}, 42, 1'b1, t0);
    drain();
    // DOT: 0.5*(1+2+3+4) - 1.0 = 4.0 exercises cancellation
    issue(2'd1, {32'h40800000, THREE, TWO, ONE}, {4{32'h3F000000}}, 32'hBF800000, 4'b1111,
          {96'd0, 32'h40800000}, 42, 1'b1, t0);
    drain();

    // SCALE by -2.0, b must be ignored
    issue(2'd2, {32'h40800000, THREE, TWO, ONE}, {4{JUNK}}, 32'hC0000000, 4'b0000,
          {32'hC1000000, 32'hC0C00000, 32'hC0800000, 32'hC0000000}, 8, 1'b1, t0);
    drain();

    // Illegal opcode behaves as MULT with the error flag
    issue(2'd3, {4{TWO}}, {4{THREE}}, JUNK, 4'b0000, {4{SIX}}, 8, 1'b1, t0);
    drain();

    // DOT then MULT: MULT stalls until the DOT has left the pipeline
    issue(2'd1, {4{TWO}}, {4{THREE}}, ONE, 4'b0101, {96'd0, THIRTEEN}, 42, 1'b1, t0);
    issue(2'd0, {4{TWO}}, {4{THREE}}, JUNK, 4'b0000, {4{SIX}}, 8, 1'b1, t1);
    check("dot_then_mult_accept", DW'(t1 - t0), DW'(43));
    drain();
    // MULT then DOT: no stall
    issue(2'd0, {4{TWO}}, {4{THREE}}, JUNK, 4'b0000, {4{SIX}}, 8, 1'b1, t0);
    issue(2'd1, {4{TWO}}, {4{THREE}}, ONE, 4'b0101, {96'd0, THIRTEEN}, 42, 1'b1, t1);
    check("mult_then_dot_accept", DW'(t1 - t0), DW'(1));
    drain();

    // Backpressure: offer 70 SCALE ops with the output blocked
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 70; i++) begin
      in_valid = 1'b1; in_op = 2'd2; in_a = {4{ONE}}; in_b = {4{JUNK}}; in_c = TWO;
      @(negedge clk);
      if (in_ready) begin
        accepted++;
        mon_e.data = {4{TWO}}; mon_e.op = 2'd2; mon_e.err = 1'b0; mon_e.cyc = -1;
        sb.push_back(mon_e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", DW'(accepted), DW'(64));
    repeat (12) @(posedge clk); #1;
    @(negedge clk);
    check("bp_full_in_ready", DW'(in_ready), '0);
    check("bp_full_out_valid", DW'(out_valid), DW'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_before_pop_in_ready", DW'(in_ready), '0);
    @(negedge clk);
    check("bp_after_pop_in_ready", DW'(in_ready), DW'(1));
    @(posedge clk); #1;
    drain();

    // Reset mid-stream: 5 results in the FIFO, 10 DOTs in flight, none may emerge
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      issue(2'd0, {4{TWO}}, {4{THREE}}, JUNK, 4'b0000, '0, -1, 1'b0, t0);
    repeat (10) @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_out_valid", DW'(out_valid), DW'(1));
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++)
      issue(2'd1, {4{TWO}}, {4{THREE}}, ONE, 4'b1111, '0, -1, 1'b0, t0);
    rst = 1'b1;
    in_op = 2'd0;
    @(negedge clk);
    check("mid_rst_in_ready", DW'(in_ready), '0);
    check("mid_rst_out_valid", DW'(out_valid), '0);
    check("mid_rst_out_data", out_data, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_m_in_ready", DW'(in_ready), DW'(1));
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("post_rst_no_output", DW'(seen), '0);
    @(posedge clk); #1;
    issue(2'd0, {4{TWO}}, {4{THREE}}, JUNK, 4'b0000, {4{SIX}}, 8, 1'b1, t0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
